// File: rtl/mmio_pkg.sv
// Shared types for the MMIO bus controller: address regions, FSM states and
// the helper that locates the region field inside the processor address.
package mmio_pkg;

   localparam int unsigned RegionW = 2;

   typedef enum logic [1:0] {
      REG_RAM  = 2'b00,
      REG_OUT  = 2'b01,
      REG_IN   = 2'b10,
      REG_NONE = 2'b11
   } region_e;

   typedef enum logic [1:0] {
      StIdle,
      StWrAck,
      StRdIssue,
      StRdData
   } state_e;

   // Region field occupies the top RegionW bits; everything below is the port index.
   function automatic int unsigned region_lsb(input int unsigned addr_w);
      return addr_w - RegionW;
   endfunction

endpackage

// File: rtl/mmio_sync2.sv
// Two-flop synchroniser for one asynchronous input port of configurable width.
module mmio_sync2 #(
   parameter int unsigned Width = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [Width-1:0] d_i,
   output logic [Width-1:0] q_o
);

   logic [Width-1:0] meta_q;
   logic [Width-1:0] sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/mmio_bus_ctrl.sv
// Handshaked MMIO controller: RAM, output registers and synchronised input ports.
// Define MMIO_READBACK_EN to let reads of the output region return register contents.
module mmio_bus_ctrl
   import mmio_pkg::*;
#(
   parameter int unsigned DATA_W  = 9,
   parameter int unsigned ADDR_W  = 9,
   parameter int unsigned RAM_AW  = 7,
   parameter int unsigned NUM_OUT = 2,
   parameter int unsigned NUM_IN  = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req,
   input  logic                      we,
   input  logic [ADDR_W-1:0]         addr,
   input  logic [DATA_W-1:0]         wdata,
   output logic                      ready,
   output logic [DATA_W-1:0]         rdata,
   output logic                      err,
   output logic                      busy,
   output logic [RAM_AW-1:0]         ram_addr,
   output logic [DATA_W-1:0]         ram_wdata,
   output logic                      ram_we,
   input  logic [DATA_W-1:0]         ram_rdata,
   output logic [NUM_OUT*DATA_W-1:0] out_data,
   input  logic [NUM_IN*DATA_W-1:0]  in_data
);

   localparam int unsigned IdxW = region_lsb(ADDR_W);

`ifdef MMIO_READBACK_EN
   localparam bit ReadbackEn = 1'b1;
`else
   localparam bit ReadbackEn = 1'b0;
`endif

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [DATA_W-1:0] out_q [NUM_OUT];
   logic [DATA_W-1:0] out_d [NUM_OUT];
   logic [DATA_W-1:0] in_sync [NUM_IN];

   region_e           region;
   logic [IdxW-1:0]   idx;
   logic              out_hit;
   logic              in_hit;
   logic [DATA_W-1:0] out_sel;
   logic [DATA_W-1:0] in_sel;
   logic [DATA_W-1:0] rd_val;
   logic              rd_err;
   logic              wr_err;

   for (genvar g = 0; g < NUM_IN; g++) begin : g_sync
      mmio_sync2 #(
         .Width (DATA_W)
      ) u_sync (
         .clk_i (clk),
         .rst_i (rst),
         .d_i   (in_data[g*DATA_W +: DATA_W]),
         .q_o   (in_sync[g])
      );
   end

   for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
      assign out_data[g*DATA_W +: DATA_W] = out_q[g];
   end

   assign region = region_e'(addr_q[ADDR_W-1 -: RegionW]);
   assign idx    = addr_q[IdxW-1:0];

   // Port selection by comparison keeps the index width independent of port count.
   always_comb begin
      out_hit = 1'b0;
      out_sel = '0;
      for (int unsigned k = 0; k < NUM_OUT; k++) begin
         if (32'(idx) == k) begin
            out_hit = 1'b1;
            out_sel = out_q[k];
         end
      end
      in_hit = 1'b0;
      in_sel = '0;
      for (int unsigned k = 0; k < NUM_IN; k++) begin
         if (32'(idx) == k) begin
            in_hit = 1'b1;
            in_sel = in_sync[k];
         end
      end
   end

   always_comb begin
      rd_val = '0;
      rd_err = 1'b0;
      wr_err = 1'b0;
      unique case (region)
         REG_RAM: begin
            rd_val = ram_rdata;
         end
         REG_OUT: begin
            rd_val = ReadbackEn ? out_sel : '0;
            rd_err = ~out_hit;
            wr_err = ~out_hit;
         end
         REG_IN: begin
            rd_val = in_sel;
            rd_err = ~in_hit;
            wr_err = 1'b1;
         end
         default: begin
            rd_err = 1'b1;
            wr_err = 1'b1;
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      out_d   = out_q;
      unique case (state_q)
         StIdle: begin
            if (req) begin
               addr_d  = addr;
               we_d    = we;
               wdata_d = wdata;
               state_d = we ? StWrAck : StRdIssue;
            end
         end
         StWrAck: begin
            if (we_q && region == REG_OUT) begin
               for (int unsigned k = 0; k < NUM_OUT; k++) begin
                  if (32'(idx) == k) out_d[k] = wdata_q;
               end
            end
            state_d = StIdle;
         end
         StRdIssue: begin
            state_d = StRdData;
         end
         StRdData: begin
            rdata_d = rd_val;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
         for (int unsigned k = 0; k < NUM_OUT; k++) out_q[k] <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         out_q   <= out_d;
      end
   end

   // Completion strobes are masked by rst so a reset cancels them within the same cycle.
   always_comb begin
      busy      = (state_q != StIdle);
      ready     = ~rst & ((state_q == StWrAck) | (state_q == StRdData));
      err       = ~rst & (((state_q == StWrAck) & wr_err) | ((state_q == StRdData) & rd_err));
      ram_we    = ~rst & (state_q == StWrAck) & we_q & (region == REG_RAM);
      ram_addr  = addr_q[RAM_AW-1:0];
      ram_wdata = wdata_q;
      rdata     = (~rst & (state_q == StRdData)) ? rd_val : rdata_q;
   end

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Directed self-checking bench for mmio_bus_ctrl with a behavioural synchronous RAM.
module tb_mmio_bus_ctrl;

   localparam int unsigned DATA_W  = 9;
   localparam int unsigned ADDR_W  = 9;
   localparam int unsigned RAM_AW  = 7;
   localparam int unsigned NUM_OUT = 2;
   localparam int unsigned NUM_IN  = 1;

`ifdef MMIO_READBACK_EN
   localparam logic [8:0] RbExp = 9'h033;
`else
   localparam logic [8:0] RbExp = 9'h000;
`endif

   logic                      clk = 1'b0;
   logic                      rst = 1'b1;
   logic                      req = 1'b0;
   logic                      we = 1'b0;
   logic [ADDR_W-1:0]         addr = '0;
   logic [DATA_W-1:0]         wdata = '0;
   logic                      ready;
   logic [DATA_W-1:0]         rdata;
   logic                      err;
   logic                      busy;
   logic [RAM_AW-1:0]         ram_addr;
   logic [DATA_W-1:0]         ram_wdata;
   logic                      ram_we;
   logic [DATA_W-1:0]         ram_rdata = '0;
   logic [NUM_OUT*DATA_W-1:0] out_data;
   logic [NUM_IN*DATA_W-1:0]  in_data = '0;

   logic [DATA_W-1:0] mem [2**RAM_AW];
   int n_cmp = 0;
   int n_bad = 0;
   int ready_cnt = 0;
   int cnt_snap;

   mmio_bus_ctrl #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .RAM_AW  (RAM_AW),
      .NUM_OUT (NUM_OUT),
      .NUM_IN  (NUM_IN)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .we        (we),
      .addr      (addr),
      .wdata     (wdata),
      .ready     (ready),
      .rdata     (rdata),
      .err       (err),
      .busy      (busy),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_we    (ram_we),
      .ram_rdata (ram_rdata),
      .out_data  (out_data),
      .in_data   (in_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   always @(posedge clk) begin
      if (ready) ready_cnt <= ready_cnt + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Accepted at the first edge; WR_ACK cycle is sampled 1 ns after it.
   task automatic bus_write(input logic [8:0] a, input logic [8:0] d, input logic exp_err,
                            input logic exp_ram, input string tag);
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = a; wdata = d;
      @(posedge clk); #1;
      req = 1'b0;
      check_eq({tag, " ready"}, 32'(ready), 32'd1);
      check_eq({tag, " err"}, 32'(err), 32'(exp_err));
      check_eq({tag, " ram_we"}, 32'(ram_we), 32'(exp_ram));
      if (exp_ram) check_eq({tag, " ram_addr"}, 32'(ram_addr), 32'(a[6:0]));
      @(posedge clk); #1;
      check_eq({tag, " ready end"}, 32'(ready), 32'd0);
      check_eq({tag, " ram_we end"}, 32'(ram_we), 32'd0);
   endtask

   task automatic bus_read(input logic [8:0] a, input logic [8:0] exp, input logic exp_err,
                           input string tag);
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = a;
      @(posedge clk); #1;
      req = 1'b0;
      check_eq({tag, " issue ready"}, 32'(ready), 32'd0);
      check_eq({tag, " issue busy"}, 32'(busy), 32'd1);
      @(posedge clk); #1;
      check_eq({tag, " ready"}, 32'(ready), 32'd1);
      check_eq({tag, " rdata"}, 32'(rdata), 32'(exp));
      check_eq({tag, " err"}, 32'(err), 32'(exp_err));
      @(posedge clk); #1;
      check_eq({tag, " ready end"}, 32'(ready), 32'd0);
      check_eq({tag, " rdata hold"}, 32'(rdata), 32'(exp));
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst ready", 32'(ready), 32'd0);
      check_eq("rst err", 32'(err), 32'd0);
      check_eq("rst busy", 32'(busy), 32'd0);
      check_eq("rst rdata", 32'(rdata), 32'd0);
      check_eq("rst ram_we", 32'(ram_we), 32'd0);
      check_eq("rst ram_addr", 32'(ram_addr), 32'd0);
      check_eq("rst ram_wdata", 32'(ram_wdata), 32'd0);
      check_eq("rst out_data", 32'(out_data), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      bus_write(9'h080, 9'h0AB, 1'b0, 1'b0, "wr out0");
      check_eq("out0 value", 32'(out_data), {14'd0, 9'h000, 9'h0AB});

      bus_write(9'h005, 9'h155, 1'b0, 1'b1, "wr ram5");
      bus_read(9'h005, 9'h155, 1'b0, "rd ram5");

      @(negedge clk);
      in_data = 9'h1F0;
      repeat (3) @(posedge clk);
      bus_read(9'h100, 9'h1F0, 1'b0, "rd in0");

      bus_read(9'h180, 9'h000, 1'b1, "rd unmapped");
      bus_write(9'h082, 9'h1FF, 1'b1, 1'b0, "wr out2");
      check_eq("out after bad wr", 32'(out_data), {14'd0, 9'h000, 9'h0AB});
      bus_read(9'h101, 9'h000, 1'b1, "rd in1");
      bus_write(9'h100, 9'h0C3, 1'b1, 1'b0, "wr in0");
      check_eq("out after in wr", 32'(out_data), {14'd0, 9'h000, 9'h0AB});

      // req held through a whole read must yield exactly one completion.
      cnt_snap = ready_cnt;
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = 9'h100;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check_eq("held ready", 32'(ready), 32'd1);
      check_eq("held rdata", 32'(rdata), 32'h1F0);
      req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("held busy", 32'(busy), 32'd0);
      check_eq("held count", 32'(ready_cnt - cnt_snap), 32'd1);

      // Reset while in RD_ISSUE.
      cnt_snap = ready_cnt;
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = 9'h005;
      @(posedge clk); #1;
      req = 1'b0;
      check_eq("pre-rst busy", 32'(busy), 32'd1);
      rst = 1'b1;
      check_eq("rst ready", 32'(ready), 32'd0);
      @(posedge clk); #1;
      check_eq("post-rst busy", 32'(busy), 32'd0);
      check_eq("post-rst out_data", 32'(out_data), 32'd0);
      check_eq("post-rst rdata", 32'(rdata), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("post-rst count", 32'(ready_cnt - cnt_snap), 32'd0);

      bus_write(9'h081, 9'h033, 1'b0, 1'b0, "wr out1");
      check_eq("out1 value", 32'(out_data), {14'd0, 9'h033, 9'h000});
      bus_read(9'h081, RbExp, 1'b0, "rd out1");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
